// File: rtl/instr_fetch_pkg.sv
// Shared fetch-stage definitions: reset address, instruction width, FSM states.
package instr_fetch_pkg;

  localparam int unsigned ILEN = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_8000;

  // REQ: a request is pending; WAIT: one request outstanding.
  typedef enum logic {
    REQ  = 1'b0,
    WAIT = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction-memory request/response channel plus the fetch-to-decode handoff.
interface instr_fetch_if;
  import instr_fetch_pkg::*;

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [31:0]     imem_req_addr;
  logic            imem_resp_valid;
  logic [ILEN-1:0] imem_resp_data;
  logic            if_valid;
  logic            id_ready;
  logic [ILEN-1:0] if_instr;
  logic [31:0]     if_pc;
  logic [31:0]     if_pc_plus4;

  // Fetch stage side.
  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready,
    input  imem_resp_valid, imem_resp_data,
    output if_valid, if_instr, if_pc, if_pc_plus4,
    input  id_ready
  );

  // Memory / decode side.
  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready,
    output imem_resp_valid, imem_resp_data,
    input  if_valid, if_instr, if_pc, if_pc_plus4,
    output id_ready
  );

endinterface

// File: rtl/instr_fetch.sv
// Fetch stage: owns the fetch PC, keeps one imem request in flight and hands
// instructions to decode through a one-entry valid/ready output register.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          redirect_valid,
  input  logic [31:0]   redirect_pc,
  instr_fetch_if.master bus
);

  fetch_state_e    state_q, state_d;
  logic            drop_q, drop_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic            if_valid_q, if_valid_d;
  logic [ILEN-1:0] if_instr_q, if_instr_d;
  logic [31:0]     if_pc_q, if_pc_d;
  logic [31:0]     if_pc_plus4_q, if_pc_plus4_d;
  logic            req_valid;
  logic            req_hs;

  // Request gating, next-state and output-register update.
  always_comb begin
    req_valid     = rstn && (state_q == REQ) && (!if_valid_q || bus.id_ready);
    req_hs        = req_valid && bus.imem_req_ready;
    state_d       = state_q;
    drop_d        = drop_q;
    fetch_pc_d    = fetch_pc_q;
    if_valid_d    = if_valid_q;
    if_instr_d    = if_instr_q;
    if_pc_d       = if_pc_q;
    if_pc_plus4_d = if_pc_plus4_q;

    if (if_valid_q && bus.id_ready) begin
      if_valid_d = 1'b0;
    end

    unique case (state_q)
      REQ: begin
        if (req_hs) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (bus.imem_resp_valid) begin
          state_d = REQ;
          drop_d  = 1'b0;
          if (!drop_q && !redirect_valid) begin
            if_instr_d    = bus.imem_resp_data;
            if_pc_d       = fetch_pc_q;
            if_pc_plus4_d = fetch_pc_q + 32'd4;
            if_valid_d    = 1'b1;
            fetch_pc_d    = fetch_pc_q + 32'd4;
          end
        end
      end
      default: state_d = REQ;
    endcase

    // Redirect overrides the above; any request still outstanding after this
    // edge targets the old PC, so its response must be discarded.
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc & ~32'h3;
      if_valid_d = 1'b0;
      if (state_d == WAIT) begin
        drop_d = 1'b1;
      end
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q       <= REQ;
      drop_q        <= 1'b0;
      fetch_pc_q    <= RESET_PC;
      if_valid_q    <= 1'b0;
      if_instr_q    <= '0;
      if_pc_q       <= '0;
      if_pc_plus4_q <= '0;
    end else begin
      state_q       <= state_d;
      drop_q        <= drop_d;
      fetch_pc_q    <= fetch_pc_d;
      if_valid_q    <= if_valid_d;
      if_instr_q    <= if_instr_d;
      if_pc_q       <= if_pc_d;
      if_pc_plus4_q <= if_pc_plus4_d;
    end
  end

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = fetch_pc_q;
  assign bus.if_valid       = if_valid_q;
  assign bus.if_instr       = if_instr_q;
  assign bus.if_pc          = if_pc_q;
  assign bus.if_pc_plus4    = if_pc_plus4_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a transaction-level reference model.
module tb_instr_fetch;

  logic        clk;
  logic        rstn;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  instr_fetch_if bus ();

  instr_fetch #(.RESET_PC(32'h0000_8000)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .bus            (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors;
  int miscompares;

  // Reference model: next PC, whether a request is outstanding, whether that
  // request has been made stale by a redirect, and the decode-facing slot.
  logic        m_init;
  logic [31:0] m_pc;
  logic        m_busy;
  logic        m_stale;
  logic        m_ov;
  logic [31:0] m_instr;
  logic [31:0] m_ipc;
  logic [31:0] m_ipc4;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_compare();
    logic exp_rv;
    if (m_init) begin
      exp_rv = rstn && !m_busy && (!m_ov || bus.id_ready);
      chk("req_valid", {31'd0, bus.imem_req_valid}, {31'd0, exp_rv});
      if (exp_rv) chk("req_addr", bus.imem_req_addr, m_pc);
      chk("if_valid", {31'd0, bus.if_valid}, {31'd0, m_ov});
      chk("if_instr", bus.if_instr, m_instr);
      chk("if_pc", bus.if_pc, m_ipc);
      chk("if_pc_plus4", bus.if_pc_plus4, m_ipc4);
    end
  endtask

  task automatic model_step();
    logic rv, hs, rsp;
    logic [31:0] rp;
    if (!rstn) begin
      m_pc = 32'h0000_8000; m_busy = 1'b0; m_stale = 1'b0; m_ov = 1'b0;
      m_instr = '0; m_ipc = '0; m_ipc4 = '0; m_init = 1'b1;
    end else if (m_init) begin
      rv  = !m_busy && (!m_ov || bus.id_ready);
      hs  = rv && bus.imem_req_ready;
      rsp = m_busy && bus.imem_resp_valid;
      if (m_ov && bus.id_ready) m_ov = 1'b0;
      if (rsp) begin
        if (!m_stale && !redirect_valid) begin
          m_instr = bus.imem_resp_data;
          m_ipc   = m_pc;
          m_ipc4  = m_pc + 32'd4;
          m_ov    = 1'b1;
          m_pc    = m_pc + 32'd4;
        end
        m_busy  = 1'b0;
        m_stale = 1'b0;
      end
      if (hs) m_busy = 1'b1;
      if (redirect_valid) begin
        rp   = redirect_pc;
        m_pc = {rp[31:2], 2'b00};
        m_ov = 1'b0;
        if (m_busy) m_stale = 1'b1;
      end
    end
  endtask

  // One clock: compare mid-cycle, advance the model on the edge, then return
  // just after the edge so the caller can drive the next cycle's inputs.
  task automatic cyc();
    @(negedge clk);
    model_compare();
    @(posedge clk);
    model_step();
    #1;
  endtask

  initial begin
    vectors = 0; miscompares = 0; m_init = 1'b0;
    m_pc = '0; m_busy = 1'b0; m_stale = 1'b0; m_ov = 1'b0;
    m_instr = '0; m_ipc = '0; m_ipc4 = '0;
    rstn = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    bus.imem_req_ready = 1'b0; bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data = '0; bus.id_ready = 1'b0;

    cyc(); cyc();
    #1;
    chk("rst_req_valid", {31'd0, bus.imem_req_valid}, 32'd0);
    chk("rst_if_valid", {31'd0, bus.if_valid}, 32'd0);
    chk("rst_if_pc", bus.if_pc, 32'd0);
    chk("rst_if_instr", bus.if_instr, 32'd0);

    // First fetch at the reset address.
    rstn = 1'b1; bus.imem_req_ready = 1'b1;
    #1;
    chk("first_req_valid", {31'd0, bus.imem_req_valid}, 32'd1);
    chk("first_req_addr", bus.imem_req_addr, 32'h0000_8000);
    cyc();
    bus.imem_req_ready = 1'b0; bus.imem_resp_valid = 1'b1; bus.imem_resp_data = 32'h0000_0013;
    cyc();
    bus.imem_resp_valid = 1'b0;
    #1;
    chk("first_if_valid", {31'd0, bus.if_valid}, 32'd1);
    chk("first_if_pc", bus.if_pc, 32'h0000_8000);
    chk("first_if_pc4", bus.if_pc_plus4, 32'h0000_8004);
    chk("first_if_instr", bus.if_instr, 32'h0000_0013);
    chk("bp_req_valid", {31'd0, bus.imem_req_valid}, 32'd0);

    // Decode backpressure for five cycles, then release.
    repeat (5) cyc();
    #1;
    chk("bp_if_pc", bus.if_pc, 32'h0000_8000);
    bus.id_ready = 1'b1;
    #1;
    chk("rel_req_valid", {31'd0, bus.imem_req_valid}, 32'd1);
    chk("rel_req_addr", bus.imem_req_addr, 32'h0000_8004);
    bus.imem_req_ready = 1'b1;
    cyc();

    // Redirect while WAIT; the late response must vanish.
    bus.imem_req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0000_9002;
    cyc();
    redirect_valid = 1'b0;
    #1;
    chk("rdw_if_valid", {31'd0, bus.if_valid}, 32'd0);
    bus.imem_resp_valid = 1'b1; bus.imem_resp_data = 32'hDEAD_BEEF;
    cyc();
    bus.imem_resp_valid = 1'b0;
    #1;
    chk("rdw_drop_valid", {31'd0, bus.if_valid}, 32'd0);
    chk("rdw_drop_instr", bus.if_instr, 32'h0000_0013);
    chk("rdw_next_addr", bus.imem_req_addr, 32'h0000_9000);

    // Redirect coincident with the response.
    bus.imem_req_ready = 1'b1;
    cyc();
    bus.imem_req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0000_9000;
    bus.imem_resp_valid = 1'b1; bus.imem_resp_data = 32'h1111_1111;
    cyc();
    redirect_valid = 1'b0; bus.imem_resp_valid = 1'b0;
    #1;
    chk("rdr_if_valid", {31'd0, bus.if_valid}, 32'd0);
    chk("rdr_next_addr", bus.imem_req_addr, 32'h0000_9000);

    // Move to 0x8004, then redirect in the same cycle as its handshake.
    redirect_valid = 1'b1; redirect_pc = 32'h0000_8004;
    cyc();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_9000; bus.imem_req_ready = 1'b1;
    #1;
    chk("rdh_req_addr", bus.imem_req_addr, 32'h0000_8004);
    cyc();
    redirect_valid = 1'b0; bus.imem_req_ready = 1'b0;
    bus.imem_resp_valid = 1'b1; bus.imem_resp_data = 32'h2222_2222;
    cyc();
    bus.imem_resp_valid = 1'b0;
    #1;
    chk("rdh_if_valid", {31'd0, bus.if_valid}, 32'd0);
    chk("rdh_next_addr", bus.imem_req_addr, 32'h0000_9000);
    bus.imem_req_ready = 1'b1;
    cyc();
    bus.imem_req_ready = 1'b0; bus.id_ready = 1'b0;
    bus.imem_resp_valid = 1'b1; bus.imem_resp_data = 32'h3333_3333;
    cyc();
    bus.imem_resp_valid = 1'b0;
    #1;
    chk("rdh_if_pc", bus.if_pc, 32'h0000_9000);
    chk("rdh_if_instr", bus.if_instr, 32'h3333_3333);

    // Wrap-around at the top of the address space.
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    cyc();
    redirect_valid = 1'b0;
    #1;
    chk("wrap_req_addr", bus.imem_req_addr, 32'hFFFF_FFFC);
    bus.imem_req_ready = 1'b1;
    cyc();
    bus.imem_req_ready = 1'b0; bus.imem_resp_valid = 1'b1; bus.imem_resp_data = 32'h0000_0013;
    cyc();
    bus.imem_resp_valid = 1'b0;
    #1;
    chk("wrap_if_pc", bus.if_pc, 32'hFFFF_FFFC);
    chk("wrap_if_pc4", bus.if_pc_plus4, 32'h0000_0000);
    bus.id_ready = 1'b1;
    #1;
    chk("wrap_next_addr", bus.imem_req_addr, 32'h0000_0000);
    bus.imem_req_ready = 1'b1;
    cyc();

    // Reset while a request is outstanding.
    bus.imem_req_ready = 1'b0; rstn = 1'b0;
    cyc();
    #1;
    chk("rstw_req_valid", {31'd0, bus.imem_req_valid}, 32'd0);
    chk("rstw_if_valid", {31'd0, bus.if_valid}, 32'd0);
    rstn = 1'b1;
    #1;
    chk("rstw_req_addr", bus.imem_req_addr, 32'h0000_8000);

    // Mixed traffic; responses only while the model has a request outstanding.
    for (int i = 0; i < 40; i++) begin
      bus.imem_req_ready  = (i % 3) != 0;
      bus.imem_resp_valid = m_busy && ((i % 2) == 1);
      bus.imem_resp_data  = 32'hA000_0000 + i;
      bus.id_ready        = (i % 4) != 3;
      redirect_valid      = (i == 17) || (i == 30);
      redirect_pc         = 32'h0000_C001 + (i << 4);
      cyc();
    end
    bus.imem_resp_valid = 1'b0; redirect_valid = 1'b0;
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
